// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, nominal bit timing and
// the serial shift helper used by the byte receiver and the UART controller.
package uart_pkg;

    // 50 MHz clock, 500 kbps line rate.
    localparam int UART_CLKS_PER_BIT = 100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } uart_state_e;

    // Serial data arrives LSB first, so each new bit enters at the top and
    // the byte is correctly aligned after the eighth shift.
    function automatic logic [7:0] shift_lsb_first(input logic [7:0] sr, input logic bit_in);
        return {bit_in, sr[7:1]};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO. Read/write pointers wrap modulo DEPTH and a
// separate occupancy count distinguishes full from empty. A pop on a full
// FIFO frees the slot so a simultaneous push is accepted.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == FULL_CNT);

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a start-bit glitch filter, frame-error detection,
// break handling (one error per held-low line) and a small output FIFO.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       uart_rx_pin,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic       rx_frame_error,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    uart_state_e      r_state;
    uart_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_error;
    logic             r_overrun;
    logic             r_busy;

    logic             w_line;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_stop_ok;
    logic             w_stop_bad;
    logic             w_pop;
    logic [7:0]       w_fifo_data;
    logic             w_fifo_valid;
    logic             w_fifo_full;

    assign w_line = r_sync2;
    assign w_pop  = w_fifo_valid && rx_ready;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_pin;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes for counter, shifter and FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_line) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_clr = 1'b1;
                    // Line back high at mid start bit: a glitch, drop it silently.
                    if (!w_line) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr = 1'b1;
                    if (w_line) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = ST_BREAK_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_BREAK_WAIT: begin
                // Wait out a held-low line so it reports only one frame error.
                w_cnt_clr = 1'b1;
                if (w_line) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BREAK_WAIT;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter; saturates so it never passes CLKS_PER_BIT-1.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_FULL) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Data shifter and bit index; the index is held at zero outside DATA.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_shift   <= shift_lsb_first(r_shift, w_line);
            r_bit_idx <= r_bit_idx + 3'd1;
        end else if (r_state != ST_DATA) begin
            r_bit_idx <= 3'd0;
        end else begin
            r_bit_idx <= r_bit_idx;
        end
    end

    // Registered status pulses and busy flag.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_error <= w_stop_bad;
            r_overrun     <= w_stop_ok && w_fifo_full && !w_pop;
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_50M),
        .i_rst_n (reset_n),
        .i_push  (w_stop_ok),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full)
    );

    assign rx_valid       = w_fifo_valid;
    assign rx_byte        = w_fifo_data;
    assign rx_frame_error = r_frame_error;
    assign rx_overrun     = r_overrun;
    assign rx_busy        = r_busy;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: directed serial frames, a queue model of the
// receive buffer checked every cycle rx_valid is high, plus literal checks.
module tb_uart_byte_receiver;

    localparam int CPB   = 100;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       pin;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_error;
    logic       rx_overrun;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pop_log[$];
    int exp_fe  = 0;
    int exp_ovr = 0;
    int fe_seen = 0;
    int ovr_seen = 0;
    int valid_hi = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic prev_v = 1'b0;

    uart_byte_receiver dut (
        .clk_50M        (clk),
        .reset_n        (reset_n),
        .uart_rx_pin    (pin),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .rx_ready       (rx_ready),
        .rx_frame_error (rx_frame_error),
        .rx_overrun     (rx_overrun),
        .rx_busy        (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: whenever the DUT presents a byte it must be the model's head.
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            check("valid_model_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rx_byte_vs_model", 32'(rx_byte), 32'(exp_q[0]));
                if (rx_ready) begin
                    pop_log.push_back(exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Pulse and valid-cycle monitor.
    always @(negedge clk) begin
        if (rx_frame_error) fe_seen++;
        if (rx_overrun) ovr_seen++;
        if (rx_valid) valid_hi++;
        if (rx_valid && !prev_v) rise_cyc = cyc;
        prev_v = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of the receive buffer: a good frame enqueues unless DEPTH bytes are pending.
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() >= DEPTH) exp_ovr++;
        else exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic release_line);
        start_cyc = cyc;
        pin = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            pin = b[i];
            tick(CPB);
        end
        pin = stop_lvl;
        tick(CPB / 2);
        if (stop_lvl) model_push(b);
        else exp_fe++;
        tick(CPB - CPB / 2);
        if (release_line) pin = 1'b1;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick(10);
        rx_ready = 1'b0;
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int fe_b;
        int ovr_b;
        int v_b;
        int lat;
        reset_n  = 1'b0;
        pin      = 1'b1;
        rx_ready = 1'b0;
        tick(5);
        reset_n = 1'b1;

        // Reset values
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_byte", 32'(rx_byte), 32'd0);
        check("rst_fe", 32'(rx_frame_error), 32'd0);
        check("rst_ovr", 32'(rx_overrun), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        tick(10);

        // Single byte 0xA5, latency about 950 cycles
        fe_b = fe_seen; ovr_b = ovr_seen;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(20);
        lat = rise_cyc - start_cyc;
        check("a5_latency_in_window", 32'((lat >= 947) && (lat <= 953)), 32'd1);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_byte", 32'(rx_byte), 32'hA5);
        check("a5_no_fe", 32'(fe_seen - fe_b), 32'd0);
        check("a5_no_ovr", 32'(ovr_seen - ovr_b), 32'd0);
        drain();

        // Five bytes into a four-deep buffer
        fe_b = fe_seen; ovr_b = ovr_seen;
        pop_log.delete();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        tick(20);
        check("of_model_depth", 32'(exp_q.size()), 32'd4);
        check("of_head", 32'(rx_byte), 32'h01);
        check("of_ovr_pulses", 32'(ovr_seen - ovr_b), 32'd1);
        check("of_model_ovr", 32'(exp_ovr), 32'd1);
        drain();
        check("of_pop_count", 32'(pop_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) check("of_pop_order", 32'(pop_log[i]), 32'(i + 1));
        end
        check("of_valid_low", 32'(rx_valid), 32'd0);

        // 30-cycle glitch on idle line
        tick(50);
        fe_b = fe_seen; v_b = valid_hi;
        pin = 1'b0;
        tick(20);
        check("gl_busy_mid", 32'(rx_busy), 32'd1);
        tick(10);
        pin = 1'b1;
        tick(25);
        check("gl_busy_55", 32'(rx_busy), 32'd0);
        tick(200);
        check("gl_no_valid", 32'(valid_hi - v_b), 32'd0);
        check("gl_no_fe", 32'(fe_seen - fe_b), 32'd0);

        // Stop bit low then break, then a clean byte
        fe_b = fe_seen;
        pop_log.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(2000);
        pin = 1'b1;
        tick(200);
        check("brk_one_fe", 32'(fe_seen - fe_b), 32'd1);
        check("brk_no_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b1);
        tick(20);
        check("brk_7e", 32'(rx_byte), 32'h7E);
        drain();
        check("brk_fe_total", 32'(fe_seen - fe_b), 32'd1);
        check("brk_model_fe", 32'(exp_fe), 32'd1);
        if (pop_log.size() == 1) check("brk_popped", 32'(pop_log[0]), 32'h7E);
        else check("brk_pop_count", 32'(pop_log.size()), 32'd1);

        // Reset pulse in the middle of a frame, then 0x55
        fe_b = fe_seen; v_b = valid_hi;
        pop_log.delete();
        pin = 1'b0;
        tick(CPB * 4 + CPB / 2 + CPB);
        reset_n = 1'b0;
        pin = 1'b1;
        tick(1);
        reset_n = 1'b1;
        exp_q.delete();
        check("mrst_busy", 32'(rx_busy), 32'd0);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        tick(300);
        check("mrst_no_byte", 32'(valid_hi - v_b), 32'd0);
        send_frame(8'h55, 1'b1, 1'b1);
        tick(20);
        check("mrst_55", 32'(rx_byte), 32'h55);
        drain();
        check("mrst_no_fe", 32'(fe_seen - fe_b), 32'd0);
        check("mrst_pop_count", 32'(pop_log.size()), 32'd1);

        // Back-to-back 0x00, 0xFF with consumer always ready
        v_b = valid_hi;
        pop_log.delete();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        tick(20);
        check("b2b_valid_cycles", 32'(valid_hi - v_b), 32'd2);
        check("b2b_pop_count", 32'(pop_log.size()), 32'd2);
        if (pop_log.size() == 2) begin
            check("b2b_first", 32'(pop_log[0]), 32'h00);
            check("b2b_second", 32'(pop_log[1]), 32'hFF);
        end
        check("b2b_ovr_none", 32'(ovr_seen), 32'd1);
        rx_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, clk_50M cycles per UART bit (500 kbps).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of received bytes buffered; power of two, 2..16.
REQ-003 clk_50M  input  1  sole clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 uart_rx_pin  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 rx_valid  output  1  high when the FIFO is non-empty; rx_byte is valid.
REQ-007 rx_byte  output  8  oldest buffered byte (FIFO head).
REQ-008 rx_ready  input  1  consumer pop; the byte is popped on a cycle where rx_valid && rx_ready.
REQ-009 rx_frame_error  output  1  one-cycle pulse when a stop bit samples low.
REQ-010 rx_overrun  output  1  one-cycle pulse when a byte completes while the FIFO is full.
REQ-011 rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 uart_rx_pin SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-014 IDLE: synchronized line low -> START, bit counter cleared.
REQ-015 START: at counter == CLKS_PER_BIT/2-1, line low -> DATA with counter cleared; line high -> IDLE (glitch rejected, nothing reported).
REQ-016 DATA: sample at counter == CLKS_PER_BIT-1, shift into bit 7 of the shift register (LSB first), clear counter; after the 8th sample -> STOP.
REQ-017 STOP: sample at counter == CLKS_PER_BIT-1; high -> byte complete, -> IDLE; low -> rx_frame_error pulse, byte discarded, -> BREAK_WAIT.
REQ-018 BREAK_WAIT: stay until the synchronized line is high, then -> IDLE; a held-low line SHALL produce exactly one frame error.
REQ-019 Bit counter width SHALL be $clog2(CLKS_PER_BIT); it never exceeds CLKS_PER_BIT-1.
REQ-020 A completed byte SHALL be written to the FIFO on the cycle after the stop sample; rx_valid visible the following cycle if the FIFO was empty.
REQ-021 FIFO full at completion: the byte is dropped, rx_overrun pulses, and existing contents are unchanged.
REQ-022 Simultaneous push and pop when full: the pop occurs first and the push succeeds; no overrun.
REQ-023 Simultaneous push and pop when empty: the pushed byte remains; rx_valid is high next cycle.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the count is kept separately at width $clog2(FIFO_DEPTH)+1.
REQ-025 rx_byte SHALL be stable while rx_valid is high and rx_ready is low.

Reset
REQ-026 When reset_n is low at an edge, state SHALL go to IDLE, the FIFO empties, and the counters clear.
REQ-027 Output reset values SHALL be rx_valid=0, rx_byte=0, rx_frame_error=0, rx_overrun=0, rx_busy=0.
REQ-028 Synchronizer flops SHALL reset to 1 (idle line).
REQ-029 Reset mid-frame SHALL abandon the frame; receiving resumes at the next falling edge after release.
REQ-030 If the line is low at reset release, START SHALL be entered and validated normally.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum and UART_CLKS_PER_BIT=100, used by this block and uart_controller.
REQ-032 The FIFO SHALL be a sub-module named byte_fifo (parameterized depth, 8-bit, synchronous, active-low reset).

Verification
REQ-033 With reset released, send 0xA5 with rx_ready=0 -> rx_valid rises 950±3 cycles after the start falling edge; rx_byte=8'hA5; no error pulses.
REQ-034 With rx_ready=0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, a single rx_overrun on the 5th byte; popping then yields 0x01,0x02,0x03,0x04 in order.
REQ-035 Apply a 30-cycle low glitch on an idle line -> no rx_valid, no rx_frame_error, rx_busy returns to 0 by cycle 55.
REQ-036 Send 0x3C with the stop bit forced low, then hold the line low for 2000 cycles, then release and send 0x7E -> exactly one rx_frame_error pulse, 0x3C not pushed, 0x7E received.
REQ-037 Assert reset_n low at bit 4 of a frame for 1 cycle, then send 0x55 -> no corrupted byte; 0x55 received correctly.
REQ-038 Hold rx_ready=1 during back-to-back 0x00 and 0xFF -> each byte is popped the cycle it appears, and rx_valid is high for exactly one cycle per byte.
